mips_avalon_arbiter: RTL and testbench
======================================

Name: mips_avalon_arbiter

Overview:
- Two-master to one-slave Avalon-MM arbiter between the MIPS CPU and the shared memory slave.
- Master 0 is the instruction-fetch port; master 1 is the data load/store port.
- Grants the slave to one master at a time and holds the grant until that transfer completes.
- Arbitration is round-robin (or fixed data-priority) with a one-cycle registered arbitration stage.

Parameters:
- RR_ENABLE, 1, 1 = round-robin on contention; 0 = data master (m1) always wins ties.
- ADDR_W, 32, address width forwarded to the slave.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  instruction master address
- m0_read  in  1  instruction master read request
- m0_waitrequest  out  1  stall to instruction master
- m0_readdata  out  32  read data to instruction master
- m1_address  in  ADDR_W  data master address
- m1_read  in  1  data master read request
- m1_write  in  1  data master write request
- m1_writedata  in  32  data master write data
- m1_byteenable  in  4  data master byte enables
- m1_waitrequest  out  1  stall to data master
- m1_readdata  out  32  read data to data master
- s_address  out  ADDR_W  address to slave
- s_read  out  1  read to slave
- s_write  out  1  write to slave
- s_writedata  out  32  write data to slave
- s_byteenable  out  4  byte enables to slave
- s_waitrequest  in  1  slave stall
- s_readdata  in  32  slave read data

Behaviour:
- Clock is clk; reset_n is asynchronous, active-low. Assertion forces state IDLE and last_grant=M0.
- Reset values of outputs:
  - s_read=0, s_write=0, s_address=0, s_writedata=0, s_byteenable=0.
  - mX_waitrequest = mX request (m0: m0_read; m1: m1_read|m1_write).
- State machine: IDLE, GNT_M0, GNT_M1 (encoding in package); last_grant register.
- IDLE:
  - No request: stay in IDLE.
  - One master requesting: go to its GNT state at the next edge.
  - Both requesting: RR_ENABLE=1 grants the master that is not last_grant; RR_ENABLE=0 grants M1.
- GNT_Mx:
  - s_* outputs are driven combinationally from master x's signals.
  - mx_waitrequest = s_waitrequest.
  - The non-granted master sees waitrequest=1 whenever it requests.
- Completion: the edge at which the granted command is high and s_waitrequest=0.
  - last_grant updates to x at that edge.
  - If the other master is requesting, go directly to its GNT state (no IDLE bubble); otherwise go to IDLE.
  - The same master re-requesting while the other waits loses under RR_ENABLE=1.
- Arbitration latency: one cycle from IDLE. A request first sampled at edge N is visible on s_* during cycle N to N+1.
- Non-granted master in any state: waitrequest=1 while it requests, 0 when idle.
- m0_readdata and m1_readdata both equal s_readdata; data is valid only on the master's own completion cycle.
- Outside GNT states, s_read=s_write=0 and s_address/s_writedata/s_byteenable=0.
- Granted master drops its command before completion: protocol error.
  - Simulation assertion ($error).
  - FSM returns to IDLE at the next edge; last_grant is unchanged.
- m1_read and m1_write both high is illegal: $fatal assertion; write takes precedence in synthesis.
- Reset mid-transfer: slave command drops immediately (asynchronous); no completion is reported to either master.

Decomposition:
- Package mips_avalon_pkg:
  - arb_state_t enum (IDLE, GNT_M0, GNT_M1).
  - master_id_t (M0, M1).
  - Constants AV_DATA_W=32 and AV_BE_W=4.
- Optional sub-module mips_avalon_rr_pick: combinational two-way round-robin chooser (req[1:0], last_grant, RR_ENABLE → winner).
- Muxing and FSM stay in the top module.

Test Plan:
- Single fetch: m0_read=1, m0_address=0xBFC00000; slave with READ_DELAY=2 holds 0x24020005.
  - s_read rises one cycle after the request.
  - m0_waitrequest falls on the completion cycle with m0_readdata=0x24020005.
  - m1_waitrequest stays 0.
- Contention, RR_ENABLE=1, from reset: m0_read and m1_read rise on the same cycle.
  - M1 is granted first; M0 follows immediately with no IDLE cycle.
  - Repeat both requests: M0 wins the next tie.
- Contention, RR_ENABLE=0: three back-to-back simultaneous requests → M1 wins all three ties.
- Data write: m1_write=1, m1_address=0x10, m1_writedata=0xDEADBEEF, m1_byteenable=4'b0011.
  - Slave word at 0x10 changes only in its low 16 bits, to 0xBEEF.
  - m0_read held meanwhile sees waitrequest=1 throughout.
- Reset mid-transfer: assert reset_n=0 while in GNT_M1 with s_waitrequest=1.
  - s_write/s_read go to 0 without waiting for a clock edge; state reads IDLE.
  - After release, the pending m0_read is served normally.
- Protocol error: m0 drops m0_read while in GNT_M0 with s_waitrequest=1 → $error is logged and the FSM reaches IDLE on the next edge.

Source files
------------

// File: rtl/mips_avalon_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_avalon_pkg
// Description : Shared types and constants for the MIPS Avalon-MM arbiter:
//               arbitration state encoding, master identifiers and bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_avalon_pkg;

    localparam int AV_DATA_W = 32;
    localparam int AV_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    // Plain-vector views of the state encoding for legacy-style FSM code.
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_GNT_M0 = GNT_M0;
    localparam logic [1:0] ST_GNT_M1 = GNT_M1;

    // The master that is not m.
    function automatic master_id_t other_master(input master_id_t m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_avalon_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_avalon_if
// Description : One Avalon-MM link (address/command/data/stall). The master
//               modport is the side that issues commands, the slave modport
//               the side that answers them.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_avalon_if #(
    parameter int ADDR_W = 32
);
    import mips_avalon_pkg::*;

    logic [ADDR_W-1:0]    address;
    logic                 read;
    logic                 write;
    logic [AV_DATA_W-1:0] writedata;
    logic [AV_BE_W-1:0]   byteenable;
    logic                 waitrequest;
    logic [AV_DATA_W-1:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface
`default_nettype wire

// File: rtl/mips_avalon_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mips_avalon_rr_pick
// Description : Combinational two-way chooser. A lone requester always wins;
//               on a tie the winner is the master not granted last time
//               (round-robin) or the data master (fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_avalon_rr_pick
    import mips_avalon_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic [1:0] req_i,
    input  master_id_t last_grant_i,
    output master_id_t winner_o
);

    // Resolve the winner from the request pair and grant history
    always_comb begin
        winner_o = M0;
        case (req_i)
            2'b01:   winner_o = M0;
            2'b10:   winner_o = M1;
            2'b11:   winner_o = RR_ENABLE ? other_master(last_grant_i) : M1;
            default: winner_o = M0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_avalon_arbiter
// Description : Two-master (instruction fetch m0, data load/store m1) to one
//               slave Avalon-MM arbiter. One registered arbitration cycle out
//               of IDLE, grant held until the transfer completes, direct
//               hand-over to a waiting master at completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_avalon_arbiter
    import mips_avalon_pkg::*;
#(
    parameter bit RR_ENABLE        = 1'b1,
    parameter int ADDR_W           = 32,
    // Simulation only: report a dropped command with $error (1) or just count it (0)
    parameter bit PROTO_ERR_REPORT = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    mips_avalon_if.slave      m0,
    mips_avalon_if.slave      m1,
    mips_avalon_if.master     s
);

    logic [1:0]  state_q, state_d;
    master_id_t  last_q, last_d;
    logic [1:0]  req;
    master_id_t  pick;

    logic [ADDR_W-1:0]    gnt_addr;
    logic                 gnt_read;
    logic                 gnt_write;
    logic [AV_DATA_W-1:0] gnt_wdata;
    logic [AV_BE_W-1:0]   gnt_be;

    // m0 never writes in practice, but both masters are treated alike
    assign req[0] = m0.read | m0.write;
    assign req[1] = m1.read | m1.write;

    mips_avalon_rr_pick #(
        .RR_ENABLE (RR_ENABLE)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_q),
        .winner_o     (pick)
    );

    // Next grant: arbitrate from IDLE, hold until completion or command drop
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = (pick == M1) ? ST_GNT_M1 : ST_GNT_M0;
                end
            end
            ST_GNT_M0: begin
                if (!req[0]) begin
                    // Command withdrawn mid-transfer: abandon it, history untouched
                    state_d = ST_IDLE;
                end else if (!s.waitrequest) begin
                    last_d  = M0;
                    state_d = req[1] ? ST_GNT_M1 : ST_IDLE;
                end
            end
            ST_GNT_M1: begin
                if (!req[1]) begin
                    state_d = ST_IDLE;
                end else if (!s.waitrequest) begin
                    last_d  = M1;
                    state_d = req[0] ? ST_GNT_M0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant state and history; reset drops the slave command at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= M0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Route the granted master to the slave and the slave stall back to it
    always_comb begin
        gnt_addr       = '0;
        gnt_read       = 1'b0;
        gnt_write      = 1'b0;
        gnt_wdata      = '0;
        gnt_be         = '0;
        m0.waitrequest = req[0];
        m1.waitrequest = req[1];
        case (state_q)
            ST_GNT_M0: begin
                gnt_addr       = m0.address;
                gnt_write      = m0.write;
                gnt_read       = m0.read & ~m0.write;
                gnt_wdata      = m0.writedata;
                gnt_be         = m0.byteenable;
                m0.waitrequest = s.waitrequest;
            end
            ST_GNT_M1: begin
                gnt_addr       = m1.address;
                gnt_write      = m1.write;
                // A simultaneous read+write is resolved as a write
                gnt_read       = m1.read & ~m1.write;
                gnt_wdata      = m1.writedata;
                gnt_be         = m1.byteenable;
                m1.waitrequest = s.waitrequest;
            end
            default: ;
        endcase
    end

    assign s.address    = gnt_addr;
    assign s.read       = gnt_read;
    assign s.write      = gnt_write;
    assign s.writedata  = gnt_wdata;
    assign s.byteenable = gnt_be;

    // Read data is shared; each master qualifies it with its own waitrequest
    assign m0.readdata  = s.readdata;
    assign m1.readdata  = s.readdata;

`ifndef SYNTHESIS
    int unsigned proto_err_cnt;

    // Flag bus-protocol violations that the hardware silently tolerates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err_cnt <= 0;
        end else begin
            if (m1.read && m1.write) begin
                $fatal(1, "mips_avalon_arbiter: m1_read and m1_write both asserted");
            end
            if ((state_q == ST_GNT_M0 && !req[0]) || (state_q == ST_GNT_M1 && !req[1])) begin
                proto_err_cnt <= proto_err_cnt + 1;
                if (PROTO_ERR_REPORT) begin
                    $error("mips_avalon_arbiter: granted master dropped its command before completion");
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_avalon_arbiter
// Description : Bench for the two-master Avalon arbiter. Lane 0 is a
//               round-robin instance, lane 1 a fixed data-priority instance,
//               each with its own slave memory (two wait states per command).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_avalon_arbiter;
    import mips_avalon_pkg::*;

    localparam int READ_DELAY = 2;

    logic clk;
    logic reset_n;

    // Master-side stimulus, one entry per lane
    logic [31:0] m0_addr [2];
    logic        m0_rd   [2];
    logic [31:0] m1_addr [2];
    logic        m1_rd   [2];
    logic        m1_wr   [2];
    logic [31:0] m1_wdata[2];
    logic [3:0]  m1_be   [2];
    logic        hold_wait[2];

    // Observed DUT outputs, one entry per lane
    logic        m0_wt [2];
    logic        m1_wt [2];
    logic        s_rd  [2];
    logic        s_wr  [2];
    logic [31:0] s_addr[2];
    logic [31:0] m0_rdata[2];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got %h, expected %h (t=%0t)", name, lane, act, exp, $time);
        end
    endtask

    for (genvar L = 0; L < 2; L++) begin : g_lane
        localparam bit RR = (L == 0);

        mips_avalon_if #(.ADDR_W(32)) m0_if ();
        mips_avalon_if #(.ADDR_W(32)) m1_if ();
        mips_avalon_if #(.ADDR_W(32)) s_if  ();

        assign m0_if.address    = m0_addr[L];
        assign m0_if.read       = m0_rd[L];
        assign m0_if.write      = 1'b0;
        assign m0_if.writedata  = 32'h0;
        assign m0_if.byteenable = 4'hF;
        assign m1_if.address    = m1_addr[L];
        assign m1_if.read       = m1_rd[L];
        assign m1_if.write      = m1_wr[L];
        assign m1_if.writedata  = m1_wdata[L];
        assign m1_if.byteenable = m1_be[L];

        mips_avalon_arbiter #(
            .RR_ENABLE        (RR),
            .ADDR_W           (32),
            .PROTO_ERR_REPORT (1'b0)
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .m0      (m0_if.slave),
            .m1      (m1_if.slave),
            .s       (s_if.master)
        );

        assign m0_wt[L]    = m0_if.waitrequest;
        assign m1_wt[L]    = m1_if.waitrequest;
        assign s_rd[L]     = s_if.read;
        assign s_wr[L]     = s_if.write;
        assign s_addr[L]   = s_if.address;
        assign m0_rdata[L] = m0_if.readdata;

        // Slave memory: every command stalls READ_DELAY cycles, then completes
        logic [31:0] mem [64];
        int          cnt;
        assign s_if.waitrequest = hold_wait[L] | ((s_if.read | s_if.write) && (cnt < READ_DELAY));
        assign s_if.readdata    = mem[s_if.address[7:2]];

        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= 0;
                for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
                mem[0] <= 32'h24020005;
                mem[4] <= 32'h11111111;
            end else if ((s_if.read | s_if.write) && !s_if.waitrequest) begin
                cnt <= 0;
                if (s_if.write) begin
                    for (int b = 0; b < 4; b++)
                        if (s_if.byteenable[b]) mem[s_if.address[7:2]][8*b +: 8] <= s_if.writedata[8*b +: 8];
                end
            end else if (s_if.read | s_if.write) begin
                cnt <= cnt + 1;
            end else begin
                cnt <= 0;
            end
        end

        // Reference model: who owns the slave (-1 none) and who finished last
        int          own = -1;
        int          last_g = 0;
        logic        q0, q1, e_rd, e_wr, e_w0, e_w1;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;

        always @(negedge clk) begin
            q0 = m0_rd[L];
            q1 = m1_rd[L] | m1_wr[L];
            if (!reset_n) begin
                own    = -1;
                last_g = 0;
            end
            e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_wd = 32'h0; e_be = 4'h0;
            e_w0 = q0;   e_w1 = q1;
            if (own == 0) begin
                e_rd = q0; e_addr = m0_addr[L]; e_be = 4'hF; e_w0 = s_if.waitrequest;
            end else if (own == 1) begin
                e_rd = m1_rd[L] & ~m1_wr[L]; e_wr = m1_wr[L]; e_addr = m1_addr[L];
                e_wd = m1_wdata[L]; e_be = m1_be[L]; e_w1 = s_if.waitrequest;
            end
            check("s_read",         L, 32'(s_if.read),        32'(e_rd));
            check("s_write",        L, 32'(s_if.write),       32'(e_wr));
            check("s_address",      L, s_if.address,          e_addr);
            check("s_writedata",    L, s_if.writedata,        e_wd);
            check("s_byteenable",   L, 32'(s_if.byteenable),  32'(e_be));
            check("m0_waitrequest", L, 32'(m0_if.waitrequest), 32'(e_w0));
            check("m1_waitrequest", L, 32'(m1_if.waitrequest), 32'(e_w1));
            check("m0_readdata",    L, m0_if.readdata,        s_if.readdata);
            check("m1_readdata",    L, m1_if.readdata,        s_if.readdata);
            if (reset_n) begin
                if (own < 0) begin
                    if (q0 && q1)  own = RR ? ((last_g == 0) ? 1 : 0) : 1;
                    else if (q1)   own = 1;
                    else if (q0)   own = 0;
                end else if (!((own == 0) ? q0 : q1)) begin
                    own = -1;
                end else if (!s_if.waitrequest) begin
                    last_g = own;
                    own    = ((own == 0) ? q1 : q0) ? (1 - own) : -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int L, input int m);
        if (m == 0) m0_rd[L] = 1'b0;
        else        m1_rd[L] = 1'b0;
    endtask

    // Advance until master m of lane L sees waitrequest low; n = cycles spent
    task automatic wait_low(input int L, input int m, output int n);
        n = 0;
        while ((((m == 0) ? m0_wt[L] : m1_wt[L]) !== 1'b0) && (n < 20)) begin
            tick();
            n++;
        end
        check("wait_bound", L, 32'(n < 20), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic xfer1(input int L, input int m);
        int n;
        if (m == 0) m0_rd[L] = 1'b1;
        else        m1_rd[L] = 1'b1;
        tick();
        wait_low(L, m, n);
        tick();
        drop(L, m);
    endtask

    // Both masters read at once; first = master granted first
    task automatic tie_round(input int L, output int first);
        int n;
        m0_addr[L] = 32'h0;
        m1_addr[L] = 32'h10;
        m0_rd[L]   = 1'b1;
        m1_rd[L]   = 1'b1;
        tick();
        first = (s_rd[L] && s_addr[L] == 32'h10) ? 1 : 0;
        wait_low(L, first, n);
        tick();
        drop(L, first);
        #1;
        check("handover_read", L, 32'(s_rd[L]), 32'd1);
        check("handover_addr", L, s_addr[L], (first == 1) ? 32'h0 : 32'h10);
        wait_low(L, 1 - first, n);
        tick();
        drop(L, 1 - first);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, bad, base;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m0_addr[i] = 32'h0; m0_rd[i] = 1'b0; m1_addr[i] = 32'h0; m1_rd[i] = 1'b0;
            m1_wr[i] = 1'b0; m1_wdata[i] = 32'h0; m1_be[i] = 4'h0; hold_wait[i] = 1'b0;
        end
        repeat (3) tick();
        check("rst_s_read",  0, 32'(s_rd[0]),  32'd0);
        check("rst_s_write", 1, 32'(s_wr[1]),  32'd0);
        check("rst_s_addr",  0, s_addr[0],     32'h0);
        check("rst_m0_wait", 0, 32'(m0_wt[0]), 32'd0);
        reset_n = 1'b1;

        // Single instruction fetch
        m0_addr[0] = 32'hBFC00000;
        m0_rd[0]   = 1'b1;
        #1;
        check("fetch_arb_cycle_read", 0, 32'(s_rd[0]),  32'd0);
        check("fetch_arb_cycle_wait", 0, 32'(m0_wt[0]), 32'd1);
        tick();
        check("fetch_s_read", 0, 32'(s_rd[0]), 32'd1);
        check("fetch_s_addr", 0, s_addr[0],    32'hBFC00000);
        wait_low(0, 0, n);
        check("fetch_latency",  0, 32'(n),       32'd2);
        check("fetch_readdata", 0, m0_rdata[0],  32'h24020005);
        check("fetch_m1_wait",  0, 32'(m1_wt[0]), 32'd0);
        tick();
        m0_rd[0] = 1'b0;
        tick();

        // Round-robin contention from reset, then after a lone data access
        do_reset();
        tie_round(0, first);
        check("rr_tie1_winner", 0, 32'(first), 32'd1);
        xfer1(0, 1);
        tie_round(0, first);
        check("rr_tie2_winner", 0, 32'(first), 32'd0);

        // Fixed priority: data master wins every tie, even right after itself
        for (int r = 0; r < 3; r++) begin
            xfer1(1, 1);
            tie_round(1, first);
            check("fp_tie_winner", 1, 32'(first), 32'd1);
        end

        // Partial-word data write while the fetch port waits
        do_reset();
        m1_addr[0] = 32'h10; m1_wdata[0] = 32'hDEADBEEF; m1_be[0] = 4'b0011; m1_wr[0] = 1'b1;
        tick();
        m0_addr[0] = 32'h0;
        m0_rd[0]   = 1'b1;
        #1;
        n = 0; bad = 0;
        while (m1_wt[0] !== 1'b0 && n < 20) begin
            if (m0_wt[0] !== 1'b1) bad++;
            tick();
            n++;
        end
        if (m0_wt[0] !== 1'b1) bad++;
        check("write_bound",      0, 32'(n < 20), 32'd1);
        check("write_m0_stalled", 0, 32'(bad),    32'd0);
        tick();
        m1_wr[0] = 1'b0;
        check("write_mem_word", 0, g_lane[0].mem[4], 32'h1111BEEF);
        wait_low(0, 0, n);
        check("after_write_fetch", 0, m0_rdata[0], 32'h24020005);
        tick();
        m0_rd[0] = 1'b0;
        tick();

        // Reset in the middle of a stalled data write
        m1_addr[1] = 32'h20; m1_wdata[1] = 32'h12345678; m1_be[1] = 4'hF; m1_wr[1] = 1'b1;
        hold_wait[1] = 1'b1;
        m0_addr[1] = 32'h0;
        m0_rd[1]   = 1'b1;
        tick();
        tick();
        check("pre_reset_s_write", 1, 32'(s_wr[1]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_s_write", 1, 32'(s_wr[1]),  32'd0);
        check("async_rst_s_read",  1, 32'(s_rd[1]),  32'd0);
        check("async_rst_state",   1, 32'(g_lane[1].u_dut.state_q), 32'(ST_IDLE));
        check("async_rst_m1_wait", 1, 32'(m1_wt[1]), 32'd1);
        m1_wr[1]     = 1'b0;
        hold_wait[1] = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_low(1, 0, n);
        check("post_rst_latency",  1, 32'(n),      32'd3);
        check("post_rst_readdata", 1, m0_rdata[1], 32'h24020005);
        tick();
        m0_rd[1] = 1'b0;
        tick();

        // Fetch master withdraws its command while stalled
        base = int'(g_lane[0].u_dut.proto_err_cnt);
        hold_wait[0] = 1'b1;
        m0_addr[0]   = 32'h0;
        m0_rd[0]     = 1'b1;
        tick();
        tick();
        m0_rd[0] = 1'b0;
        tick();
        check("proto_s_read",  0, 32'(s_rd[0]), 32'd0);
        check("proto_state",   0, 32'(g_lane[0].u_dut.state_q), 32'(ST_IDLE));
        check("proto_err_cnt", 0, 32'(g_lane[0].u_dut.proto_err_cnt), 32'(base + 1));
        hold_wait[0] = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
